pcounter_sched: RTL and testbench

Round-robin scheduler sharing one up-counter between two requesters. Each requester asks for a timed run with its own terminal count. The block grants one requester at a time, runs the shared count from 0 to that requester's target, then pulses a completion strobe back to it. It sits between the requesting control logic and the counter datapath, sequencing clear/run/stop for the counter.

---
 rtl/psched_pkg.sv | 16 +
 rtl/psched_rr_arb.sv | 36 +++
 rtl/pcounter_sched.sv | 118 +++++++++++
 tb/tb_pcounter_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psched_pkg.sv
// Shared types for the pcounter_sched round-robin counter scheduler.
// Holds the FSM state encoding, requester index type and arbitration reset value.
package psched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_idx_t;

    // last=1 after reset so requester 0 wins the first contended grant.
    localparam req_idx_t LAST_RESET = 1'b1;

endpackage

// File: rtl/psched_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that did not win last time. Purely combinational.
module psched_rr_arb
    import psched_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    input  logic       enable,
    output logic [1:0] win,
    output req_idx_t   win_idx
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        win     = 2'b00;
        win_idx = 1'b0;
        if (enable) begin
            unique case (req)
                2'b01: begin
                    win     = 2'b01;
                    win_idx = 1'b0;
                end
                2'b10: begin
                    win     = 2'b10;
                    win_idx = 1'b1;
                end
                2'b11: begin
                    win_idx = ~last;
                    win     = last ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pcounter_sched.sv
// Shares one up-counter between two requesters: grant, count 0..target, pulse done.
// Optional macro PSCHED_PAUSE_EN adds a pause input that freezes the count in RUN.
module pcounter_sched
    import psched_pkg::*;
#(
    parameter int N = 7
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [1:0]   req,
    input  logic [N:0]   target0,
    input  logic [N:0]   target1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [N:0]   count,
    output logic         busy
`ifdef PSCHED_PAUSE_EN
    ,
    input  logic         pause
`endif
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    state_t     state, state_next;
    logic [1:0] gnt_next, done_next;
    logic [N:0] count_next;
    logic [N:0] tgt_q, tgt_next;
    req_idx_t   last, last_next;
    req_idx_t   owner, owner_next;
    logic [1:0] win;
    req_idx_t   win_idx;
    logic       hold;

`ifdef PSCHED_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    psched_rr_arb u_arb (
        .req     (req),
        .last    (last),
        .enable  (state == IDLE),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        done_next  = 2'b00;
        count_next = count;
        tgt_next   = tgt_q;
        last_next  = last;
        owner_next = owner;

        unique case (state)
            IDLE: begin
                count_next = '0;
                gnt_next   = 2'b00;
                if (win != 2'b00) begin
                    tgt_next   = win_idx ? target1 : target0;
                    gnt_next   = win;
                    owner_next = win_idx;
                    last_next  = win_idx;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Paused cycles neither advance the count nor allow completion.
                if (!hold) begin
                    if (count == tgt_q) begin
                        state_next       = DONE;
                        gnt_next         = 2'b00;
                        done_next[owner] = 1'b1;
                    end else begin
                        count_next = count + ONE;
                    end
                end
            end
            DONE: begin
                count_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
                count_next = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values computed in the combinational block.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            gnt   <= 2'b00;
            done  <= 2'b00;
            count <= '0;
            tgt_q <= '0;
            last  <= LAST_RESET;
            owner <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            done  <= done_next;
            count <= count_next;
            tgt_q <= tgt_next;
            last  <= last_next;
            owner <= owner_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pcounter_sched.sv
// Directed self-checking bench for pcounter_sched (N=7).
// Define PSCHED_PAUSE_EN for both RTL and bench to exercise the pause path.
module tb_pcounter_sched;

    localparam int N = 7;

    logic         clock;
    logic         clear;
    logic [1:0]   req;
    logic [N:0]   target0;
    logic [N:0]   target1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [N:0]   count;
    logic         busy;
`ifdef PSCHED_PAUSE_EN
    logic         pause;
`endif

    int checks = 0;
    int errors = 0;

    pcounter_sched #(.N(N)) dut (
        .clock   (clock),
        .clear   (clear),
        .req     (req),
        .target0 (target0),
        .target1 (target1),
        .gnt     (gnt),
        .done    (done),
        .count   (count),
        .busy    (busy)
`ifdef PSCHED_PAUSE_EN
        ,
        .pause   (pause)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_outs(input string name, input logic [1:0] eg,
                               input logic [1:0] ed, input logic [N:0] ec,
                               input logic eb);
        checks++;
        if (gnt !== eg || done !== ed || count !== ec || busy !== eb) begin
            errors++;
            $display("FAIL %s: got gnt=%b done=%b count=%0d busy=%b, want gnt=%b done=%b count=%0d busy=%b",
                     name, gnt, done, count, busy, eg, ed, ec, eb);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        clear = 1'b0;
        expect_outs("reset", 2'b00, 2'b00, 8'd0, 1'b0);
        tick();
        expect_outs("reset_idle_hold", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_basic();
        target0 = 8'd3;
        req     = 2'b01;
        tick();
        expect_outs("basic_grant", 2'b01, 2'b00, 8'd0, 1'b1);
        req     = 2'b00;
        target0 = 8'd1;     // changes after grant must be ignored
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_outs($sformatf("basic_count%0d", k), 2'b01, 2'b00, k[N:0], 1'b1);
        end
        tick();
        expect_outs("basic_done", 2'b00, 2'b01, 8'd3, 1'b1);
        tick();
        expect_outs("basic_idle", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        int t;
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        target0 = 8'd2;
        target1 = 8'd4;
        req     = 2'b11;
        tick();
        for (int r = 0; r < 4; r++) begin
            eg = (r % 2 == 0) ? 2'b01 : 2'b10;
            t  = (r % 2 == 0) ? 2 : 4;
            expect_outs($sformatf("cont_grant%0d", r), eg, 2'b00, 8'd0, 1'b1);
            if (r == 3) req = 2'b00;
            repeat (t) tick();
            expect_outs($sformatf("cont_last_count%0d", r), eg, 2'b00, t[N:0], 1'b1);
            tick();
            expect_outs($sformatf("cont_done%0d", r), 2'b00, eg, t[N:0], 1'b1);
            tick();
            expect_outs($sformatf("cont_idle%0d", r), 2'b00, 2'b00, 8'd0, 1'b0);
            if (r < 3) tick();
        end
        tick();
        expect_outs("cont_quiet", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_zero_target();
        target1 = 8'd0;
        req     = 2'b10;
        tick();
        expect_outs("zero_grant", 2'b10, 2'b00, 8'd0, 1'b1);
        req = 2'b00;
        tick();
        expect_outs("zero_done", 2'b00, 2'b10, 8'd0, 1'b1);
        tick();
        expect_outs("zero_idle", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_midrun_reset();
        target1 = 8'd9;
        req     = 2'b10;
        tick();
        expect_outs("mid_grant", 2'b10, 2'b00, 8'd0, 1'b1);
        req = 2'b00;
        repeat (5) tick();
        expect_outs("mid_count5", 2'b10, 2'b00, 8'd5, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_outs("mid_cleared", 2'b00, 2'b00, 8'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            expect_outs($sformatf("mid_no_done%0d", i), 2'b00, 2'b00, 8'd0, 1'b0);
        end
        target0 = 8'd1;
        req     = 2'b11;
        tick();
        expect_outs("mid_regrant_req0", 2'b01, 2'b00, 8'd0, 1'b1);
        req = 2'b00;
        tick();
        expect_outs("mid_regrant_count1", 2'b01, 2'b00, 8'd1, 1'b1);
        tick();
        expect_outs("mid_regrant_done", 2'b00, 2'b01, 8'd1, 1'b1);
        tick();
        expect_outs("mid_regrant_idle", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_max_target();
        int bad = 0;
        target0 = 8'd255;
        req     = 2'b01;
        tick();
        expect_outs("max_grant", 2'b01, 2'b00, 8'd0, 1'b1);
        req     = 2'b00;
        target0 = 8'd0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (count !== k[N:0] || gnt !== 2'b01 || done !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_ramp: %0d cycles off the 1..255 ramp, want 0", bad);
        end
        tick();
        expect_outs("max_done", 2'b00, 2'b01, 8'd255, 1'b1);
        tick();
        expect_outs("max_idle", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Requester 1 re-requests immediately; with only one requester it wins again.
        target1 = 8'd1;
        req     = 2'b10;
        tick();
        expect_outs("b2b_grant_a", 2'b10, 2'b00, 8'd0, 1'b1);
        repeat (2) tick();
        expect_outs("b2b_done_a", 2'b00, 2'b10, 8'd1, 1'b1);
        tick();
        expect_outs("b2b_idle", 2'b00, 2'b00, 8'd0, 1'b0);
        tick();
        expect_outs("b2b_grant_b", 2'b10, 2'b00, 8'd0, 1'b1);
        req = 2'b00;
        repeat (2) tick();
        expect_outs("b2b_done_b", 2'b00, 2'b10, 8'd1, 1'b1);
        tick();
        expect_outs("b2b_end", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask

`ifdef PSCHED_PAUSE_EN
    task automatic test_pause();
        target0 = 8'd4;
        req     = 2'b01;
        tick();
        expect_outs("pause_grant", 2'b01, 2'b00, 8'd0, 1'b1);
        req = 2'b00;
        repeat (2) tick();
        expect_outs("pause_count2", 2'b01, 2'b00, 8'd2, 1'b1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_outs($sformatf("pause_hold%0d", i), 2'b01, 2'b00, 8'd2, 1'b1);
        end
        pause = 1'b0;
        tick();
        expect_outs("pause_count3", 2'b01, 2'b00, 8'd3, 1'b1);
        tick();
        expect_outs("pause_count4", 2'b01, 2'b00, 8'd4, 1'b1);
        tick();
        expect_outs("pause_done", 2'b00, 2'b01, 8'd4, 1'b1);
        tick();
        expect_outs("pause_idle", 2'b00, 2'b00, 8'd0, 1'b0);
    endtask
`endif

    initial begin
        clear   = 1'b1;
        req     = 2'b00;
        target0 = '0;
        target1 = '0;
`ifdef PSCHED_PAUSE_EN
        pause   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_contention();
        test_zero_target();
        test_midrun_reset();
        test_max_target();
        test_back_to_back();
`ifdef PSCHED_PAUSE_EN
        test_pause();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
